// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control codes used by the ALU decoder and the mul/div unit.
package mips_pkg;

  typedef enum logic [4:0] {
    AluMult  = 5'b10000,
    AluMultu = 5'b10001,
    AluDiv   = 5'b10010,
    AluDivu  = 5'b10011,
    AluMtlo  = 5'b10101,
    AluMthi  = 5'b10110
  } alu_control_t;

  function automatic logic is_muldiv_op(input logic [4:0] code);
    case (alu_control_t'(code))
      AluMult, AluMultu, AluDiv, AluDivu, AluMtlo, AluMthi: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle after a one-cycle load.
module div_core #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o
);

  localparam logic [5:0] LastCnt = 6'(Width - 1);

  logic [5:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] dvs_q, dvs_d;
  logic [Width:0]   rem_shift, diff;

  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    rem_shift = {rem_q, quo_q[Width-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    // done marks the cycle whose closing edge retires the final quotient bit
    done_o    = busy_q && (cnt_q == LastCnt);
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      if (!diff[Width]) begin
        rem_d = diff[Width-1:0];
        quo_d = {quo_q[Width-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[Width-1:0];
        quo_d = {quo_q[Width-2:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy_o      = busy_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_controller.sv
// HI/LO multiply/divide unit: FSM, operand sign handling and HI/LO registers around div_core.
module muldiv_controller
  import mips_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [4:0]           op,
  input  logic [DIV_STEPS-1:0] rs_data,
  input  logic [DIV_STEPS-1:0] rt_data,
  input  logic                 mf_req,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [DIV_STEPS-1:0] hi,
  output logic [DIV_STEPS-1:0] lo
);

  localparam int unsigned W = DIV_STEPS;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDz} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           sgn_q, sgn_d;
  logic           neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic           done_q, done_d;

  alu_control_t   op_e;
  logic           accept, rt_zero, div_signed;
  logic [W-1:0]   rs_abs, rt_abs;
  logic [2*W-1:0] ext_a, ext_b, prod;
  logic           div_start, div_busy, div_done;
  logic [W-1:0]   div_quo, div_rem;

  assign op_e       = alu_control_t'(op);
  assign accept     = start && (state_q == StIdle) && is_muldiv_op(op);
  assign rt_zero    = (rt_data == '0);
  assign div_signed = (op_e == AluDiv);
  assign rs_abs     = (div_signed && rs_data[W-1]) ? -rs_data : rs_data;
  assign rt_abs     = (div_signed && rt_data[W-1]) ? -rt_data : rt_data;

  // Sign-extend to 2W so the low 2W product bits are right for both MULT and MULTU
  assign ext_a = {{W{sgn_q & a_q[W-1]}}, a_q};
  assign ext_b = {{W{sgn_q & b_q[W-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  div_core #(
    .Width(W)
  ) u_div_core (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .start_i    (div_start),
    .dividend_i (a_q),
    .divisor_i  (b_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op_e)
            AluMult, AluMultu: state_d = StMul;
            AluDiv, AluDivu:   state_d = rt_zero ? StDz : StDiv;
            default:           state_d = StIdle;
          endcase
        end
      end
      StDiv:   if (div_done) state_d = StFix;
      StMul, StFix, StDz: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    busy      = (state_q != StIdle);
    stall     = busy & (start | mf_req);
    done      = done_q;
    hi        = hi_q;
    lo        = lo_q;
    // Launch the core on the first DIV cycle only; it stays busy until its last step
    div_start = (state_q == StDiv) && !div_busy;

    if (accept) begin
      case (op_e)
        AluMthi: hi_d = rs_data;
        AluMtlo: lo_d = rs_data;
        AluMult, AluMultu: begin
          a_d   = rs_data;
          b_d   = rt_data;
          sgn_d = (op_e == AluMult);
        end
        AluDiv, AluDivu: begin
          if (rt_zero) begin
            a_d = rs_data;
          end else begin
            a_d       = rs_abs;
            b_d       = rt_abs;
            neg_quo_d = div_signed && (rs_data[W-1] ^ rt_data[W-1]);
            neg_rem_d = div_signed && rs_data[W-1];
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      StMul: begin
        {hi_d, lo_d} = prod;
        done_d       = 1'b1;
      end
      StDz: begin
        hi_d   = a_q;
        lo_d   = '1;
        done_d = 1'b1;
      end
      StFix: begin
        lo_d   = neg_quo_q ? -div_quo : div_quo;
        hi_d   = neg_rem_q ? -div_rem : div_rem;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule
